// File: rtl/sd_out_conv_if.sv
// Bus between the signed-digit output converter and its neighbours.
// The slave view belongs to the converter: it receives the filter's digit word
// and serves the buffered two's-complement results to the consumer.
// The master view is the filter/consumer side.
interface sd_out_conv_if #(
  parameter int Stage = 8,
  parameter int OW    = 8
);
  logic                 in_valid;
  logic [2*Stage-1:0]   din;
  logic                 out_valid;
  logic                 out_ready;
  logic [OW-1:0]        dout;
  logic                 dout_sat;
  logic [7:0]           drop_cnt;

  modport slave (
    input  in_valid, din, out_ready,
    output out_valid, dout, dout_sat, drop_cnt
  );

  modport master (
    output in_valid, din, out_ready,
    input  out_valid, dout, dout_sat, drop_cnt
  );
endinterface

// File: rtl/sd_out_conv.sv
// Signed-digit (P - N) to two's-complement converter for the online IIR output.
// A chunked borrow pipeline resolves CHUNK bits per stage, the final value is
// saturated to OW bits and queued in a DEPTH-entry FIFO (no fall-through).
// The input side cannot be stalled: results meeting a full FIFO are dropped
// and counted in a saturating 8-bit counter.
module sd_out_conv #(
  parameter int Stage = 8,
  parameter int CHUNK = 4,
  parameter int OW    = 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            enable,
  sd_out_conv_if.slave    bus
);

  localparam int NP       = (Stage + CHUNK - 32'sd1) / CHUNK;
  localparam int PW       = NP * CHUNK;
  localparam int AW       = $clog2(DEPTH);
  localparam int SAT_HI_I = (32'sd1 << (OW - 32'sd1)) - 32'sd1;
  localparam int SAT_LO_I = -SAT_HI_I - 32'sd1;
  localparam logic signed [Stage:0] SAT_HI  = SAT_HI_I[Stage:0];
  localparam logic signed [Stage:0] SAT_LO  = SAT_LO_I[Stage:0];
  localparam logic [AW:0]           DEPTH_C = DEPTH[AW:0];

  // Clamp a resolved value to the output range; returns {sat, value}.
  function automatic logic [OW:0] sat_fn(input logic signed [Stage:0] v);
    logic [OW:0] r;
    if (v > SAT_HI) begin
      r = {1'b1, SAT_HI[OW-1:0]};
    end else if (v < SAT_LO) begin
      r = {1'b1, SAT_LO[OW-1:0]};
    end else begin
      r = {1'b0, v[OW-1:0]};
    end
    return r;
  endfunction

  // Decoded plus/minus vectors, zero padded to a whole number of chunks.
  logic [PW-1:0]   p_in_s, n_in_s;

  // Per-stage source operands and next values.
  logic [PW-1:0]   src_p_s   [NP];
  logic [PW-1:0]   src_n_s   [NP];
  logic [PW-1:0]   src_res_s [NP];
  logic            src_b_s   [NP];
  logic [CHUNK:0]  diff_s    [NP];
  logic [PW-1:0]   nxt_res_s [NP];
  logic            nxt_b_s   [NP];

  // Pipeline registers: raw bits still to resolve, partial result, borrow.
  logic [NP-1:0]   vld_r;
  logic [PW-1:0]   p_r   [NP];
  logic [PW-1:0]   n_r   [NP];
  logic [PW-1:0]   res_r [NP];
  logic            b_r   [NP];

  // FIFO state and registered outputs.
  logic [OW:0]     mem_r [DEPTH];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [AW:0]     cnt_r, cnt_nxt_s;
  logic            out_valid_r, dout_sat_r;
  logic [OW-1:0]   dout_r;
  logic [7:0]      drop_cnt_r;

  logic [PW:0]     fin_s;
  logic [Stage:0]  v_s;
  logic [OW:0]     wdata_s, head_nxt_s;
  logic            wr_req_s, full_s, pop_s, push_s, drop_s;

  // Split the digit word into its plus and minus bit vectors.
  always_comb begin
    p_in_s = '0;
    n_in_s = '0;
    for (int i = 0; i < Stage; i++) begin
      p_in_s[i] = bus.din[2*i+1];
      n_in_s[i] = bus.din[2*i];
    end
  end

  // Each stage subtracts its chunk of N (and the incoming borrow) from P.
  always_comb begin
    src_p_s[0]   = p_in_s;
    src_n_s[0]   = n_in_s;
    src_res_s[0] = '0;
    src_b_s[0]   = 1'b0;
    for (int s = 1; s < NP; s++) begin
      src_p_s[s]   = p_r[s-1];
      src_n_s[s]   = n_r[s-1];
      src_res_s[s] = res_r[s-1];
      src_b_s[s]   = b_r[s-1];
    end
    for (int s = 0; s < NP; s++) begin
      diff_s[s] = {1'b0, src_p_s[s][s*CHUNK +: CHUNK]}
                - {1'b0, src_n_s[s][s*CHUNK +: CHUNK]}
                - {{CHUNK{1'b0}}, src_b_s[s]};
      nxt_res_s[s] = src_res_s[s];
      nxt_res_s[s][s*CHUNK +: CHUNK] = diff_s[s][CHUNK-1:0];
      nxt_b_s[s] = diff_s[s][CHUNK];
    end
  end

  // Advance the borrow pipeline; dropping enable flushes every stage.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_r <= '0;
      for (int s = 0; s < NP; s++) begin
        p_r[s]   <= '0;
        n_r[s]   <= '0;
        res_r[s] <= '0;
        b_r[s]   <= 1'b0;
      end
    end else begin
      vld_r[0] <= enable & bus.in_valid;
      for (int s = 1; s < NP; s++) begin
        vld_r[s] <= enable & vld_r[s-1];
      end
      if (enable) begin
        for (int s = 0; s < NP; s++) begin
          p_r[s]   <= src_p_s[s];
          n_r[s]   <= src_n_s[s];
          res_r[s] <= nxt_res_s[s];
          b_r[s]   <= nxt_b_s[s];
        end
      end
    end
  end

  // The final borrow is the sign: value = res - borrow * 2^PW.
  assign fin_s   = {b_r[NP-1], res_r[NP-1]};
  assign v_s     = fin_s[Stage:0];
  assign wdata_s = sat_fn(v_s);

  // FIFO bookkeeping: push/pop/drop decisions and the next head word.
  always_comb begin
    wr_req_s = enable & vld_r[NP-1];
    pop_s    = out_valid_r & bus.out_ready;
    full_s   = (cnt_r == DEPTH_C);
    push_s   = wr_req_s & (~full_s | pop_s);
    drop_s   = wr_req_s & ~push_s;
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = cnt_r + (AW+1)'(1'b1);
      2'b01:   cnt_nxt_s = cnt_r - (AW+1)'(1'b1);
      default: cnt_nxt_s = cnt_r;
    endcase
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
      head_nxt_s = wdata_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage array; contents need no reset since the count guards them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata_s;
    end
  end

  // FIFO pointers, count, registered head outputs and the drop counter.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      out_valid_r <= 1'b0;
      dout_r      <= '0;
      dout_sat_r  <= 1'b0;
      drop_cnt_r  <= 8'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      rd_ptr_r    <= rd_ptr_nxt_s;
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= (cnt_nxt_s != '0);
      if (cnt_nxt_s != '0) begin
        {dout_sat_r, dout_r} <= head_nxt_s;
      end
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dout      = dout_r;
  assign bus.dout_sat  = dout_sat_r;
  assign bus.drop_cnt  = drop_cnt_r;

endmodule
